// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS I integer core, Harvard buses, one branch delay slot.
// Halts itself when the PC reaches 0 and exposes $v0 for result checking.
module mips_harvard_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  localparam logic [5:0] OP_R = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23,
                         OP_SW = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                         F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic [31:0] pc, npc;
  logic [31:0] gpr [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_v, rt_v, imm_s, imm_z, pc4, br_tgt, mem_addr;
  logic        wr_en, taken, is_lw, is_sw, run;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, tgt;

  assign op    = instr_readdata[31:26];
  assign rs    = instr_readdata[25:21];
  assign rt    = instr_readdata[20:16];
  assign rd    = instr_readdata[15:11];
  assign shamt = instr_readdata[10:6];
  assign funct = instr_readdata[5:0];
  assign imm   = instr_readdata[15:0];

  assign rs_v     = gpr[rs];
  assign rt_v     = gpr[rt];
  assign imm_s    = {{16{imm[15]}}, imm};
  assign imm_z    = {16'd0, imm};
  assign pc4      = pc + 32'd4;
  assign br_tgt   = pc4 + {imm_s[29:0], 2'b00};
  assign mem_addr = rs_v + imm_s;

  // Once the PC reaches 0 the core is parked: no writes, no strobes.
  assign run = active && (pc != 32'd0);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = 32'd0;
    taken   = 1'b0;
    tgt     = br_tgt;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    case (op)
      OP_R: begin
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          F_SLL:  wr_data = rt_v << shamt;
          F_SRL:  wr_data = rt_v >> shamt;
          F_SRA:  wr_data = 32'($signed(rt_v) >>> shamt);
          F_SLLV: wr_data = rt_v << rs_v[4:0];
          F_SRLV: wr_data = rt_v >> rs_v[4:0];
          F_SRAV: wr_data = 32'($signed(rt_v) >>> rs_v[4:0]);
          F_ADDU: wr_data = rs_v + rt_v;
          F_SUBU: wr_data = rs_v - rt_v;
          F_AND:  wr_data = rs_v & rt_v;
          F_OR:   wr_data = rs_v | rt_v;
          F_XOR:  wr_data = rs_v ^ rt_v;
          F_NOR:  wr_data = ~(rs_v | rt_v);
          F_SLT:  wr_data = {31'd0, $signed(rs_v) < $signed(rt_v)};
          F_SLTU: wr_data = {31'd0, rs_v < rt_v};
          F_JR: begin
            wr_en = 1'b0;
            taken = 1'b1;
            tgt   = rs_v;
          end
          F_JALR: begin
            taken   = 1'b1;
            tgt     = rs_v;
            wr_data = pc + 32'd8;
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'd0)      taken = rs_v[31];
        else if (rt == 5'd1) taken = !rs_v[31];
      end
      OP_J: begin
        taken = 1'b1;
        tgt   = {pc4[31:28], instr_readdata[25:0], 2'b00};
      end
      OP_JAL: begin
        taken   = 1'b1;
        tgt     = {pc4[31:28], instr_readdata[25:0], 2'b00};
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc + 32'd8;
      end
      OP_BEQ:   taken = (rs_v == rt_v);
      OP_BNE:   taken = (rs_v != rt_v);
      OP_BLEZ:  taken = rs_v[31] || (rs_v == 32'd0);
      OP_BGTZ:  taken = !rs_v[31] && (rs_v != 32'd0);
      OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_v + imm_s; end
      OP_SLTI:  begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_v) < $signed(imm_s)}; end
      OP_SLTIU: begin wr_en = 1'b1; wr_data = {31'd0, rs_v < imm_s}; end
      OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_v & imm_z; end
      OP_ORI:   begin wr_en = 1'b1; wr_data = rs_v | imm_z; end
      OP_XORI:  begin wr_en = 1'b1; wr_data = rs_v ^ imm_z; end
      OP_LUI:   begin wr_en = 1'b1; wr_data = {imm, 16'd0}; end
      OP_LW: begin
        is_lw   = 1'b1;
        wr_en   = 1'b1;
        wr_data = data_readdata;
      end
      OP_SW:    is_sw = 1'b1;
      default:  ;
    endcase
  end

  assign instr_address  = pc;
  assign register_v0    = gpr[2];
  assign data_address   = mem_addr;
  assign data_writedata = rt_v;
  assign data_read      = !reset && run && is_lw;
  // Gated with clk_enable so a frozen store never commits.
  assign data_write     = !reset && run && is_sw && clk_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      npc    <= RESET_PC + 32'd4;
      active <= 1'b1;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (clk_enable && run) begin
      pc  <= npc;
      npc <= taken ? tgt : npc + 32'd4;
      if (npc == 32'd0) active <= 1'b0;
      if (wr_en && (wr_addr != 5'd0)) gpr[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Scoreboard bench: directed programs push expected stores, loads, halts and
// probes into queues; monitors pop and compare when the core presents them.
module tb_mips_harvard_cpu;
  localparam logic [31:0] BOOT = 32'hBFC0_0000;

  logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b1;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  mips_harvard_cpu dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .register_v0(register_v0), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] halt_word;

  assign instr_readdata = (instr_address == 32'd0) ? halt_word :
                          (instr_address[31:8] == 24'hBFC000) ? imem[instr_address[7:2]] : 32'd0;
  assign data_readdata  = dmem[data_address[7:2]];
  always @(posedge clk) if (data_write) dmem[data_address[7:2]] <= data_writedata;

  int edges;
  always @(posedge clk or posedge reset)
    if (reset) edges <= 0;
    else if (clk_enable) edges <= edges + 1;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] d;
    logic        act;
    int          n;
  } exp_t;

  exp_t st_q[$], ld_q[$], halt_q[$], pr_q[$];
  int n_cmp = 0, n_bad = 0;
  event probe_ev;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic unexpected(string nm, logic [31:0] got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event value %h expected none", nm, got);
  endtask

  // Output monitor: stores, loads and halt events.
  logic prev_act;
  always @(negedge clk) begin : mon
    exp_t e;
    if (data_write) begin
      if (st_q.size() == 0) unexpected("store", data_address);
      else begin
        e = st_q.pop_front();
        chk({e.nm, ".addr"}, data_address, e.a);
        chk({e.nm, ".data"}, data_writedata, e.d);
      end
    end
    if (data_read) begin
      if (ld_q.size() == 0) unexpected("load", data_address);
      else begin
        e = ld_q.pop_front();
        chk({e.nm, ".addr"}, data_address, e.a);
      end
    end
    if (prev_act === 1'b1 && active === 1'b0) begin
      if (halt_q.size() == 0) unexpected("halt", register_v0);
      else begin
        e = halt_q.pop_front();
        chk({e.nm, ".v0"}, register_v0, e.d);
        chk({e.nm, ".cycles"}, 32'(edges), 32'(e.n));
      end
    end
    prev_act <= active;
  end

  always @(probe_ev) begin : prb
    exp_t e;
    if (pr_q.size() > 0) begin
      e = pr_q.pop_front();
      chk({e.nm, ".active"}, {31'd0, active}, {31'd0, e.act});
      chk({e.nm, ".pc"}, instr_address, e.a);
      chk({e.nm, ".v0"}, register_v0, e.d);
    end
  end

  task automatic exp_st(string nm, logic [31:0] a, logic [31:0] d);
    exp_t e; e.nm = nm; e.a = a; e.d = d; e.act = 1'b0; e.n = 0;
    st_q.push_back(e);
  endtask
  task automatic exp_ld(string nm, logic [31:0] a);
    exp_t e; e.nm = nm; e.a = a; e.d = 32'd0; e.act = 1'b0; e.n = 0;
    ld_q.push_back(e);
  endtask
  task automatic exp_halt(string nm, logic [31:0] v0, int n);
    exp_t e; e.nm = nm; e.a = 32'd0; e.d = v0; e.act = 1'b0; e.n = n;
    halt_q.push_back(e);
  endtask
  task automatic probe(string nm, logic act, logic [31:0] pc, logic [31:0] v0);
    exp_t e; e.nm = nm; e.a = pc; e.d = v0; e.act = act; e.n = 0;
    pr_q.push_back(e);
    ->probe_ev;
  endtask

  function automatic logic [31:0] ri(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] ii(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jj(int op, logic [31:0] addr);
    return {6'(op), addr[27:2]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    clk_enable = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_to_halt(string nm, int max);
    int k = 0;
    while (active && k < max) begin
      @(negedge clk);
      k++;
    end
    if (active) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got active=1 after %0d cycles expected halt", nm, max);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADDIU then halt; a store at address 0 must never execute.
    clear_imem();
    imem[0] = ii(9, 0, 2, 16'd5);
    imem[1] = ri(0, 0, 0, 0, 8);
    halt_word = ii(43, 0, 2, 16'd0);
    do_reset();
    #1 probe("t1_reset", 1'b1, BOOT, 32'd0);
    exp_halt("t1_halt", 32'd5, 3);
    run_to_halt("t1", 20);
    #1 probe("t1_held", 1'b0, 32'd0, 32'd5);

    // Arithmetic, logic, shifts, compares; results stored for checking.
    clear_imem();
    imem[0]  = ii(15, 0, 3, 16'h8000);
    imem[1]  = ri(0, 3, 2, 4, 3);
    imem[2]  = ii(43, 0, 2, 16'd0);
    imem[3]  = ii(9, 0, 4, 16'hFFFF);
    imem[4]  = ri(0, 4, 2, 0, 'h2B);
    imem[5]  = ri(0, 3, 6, 4, 2);
    imem[6]  = ri(4, 0, 7, 0, 'h2A);
    imem[7]  = ri(4, 0, 8, 0, 'h2B);
    imem[8]  = ri(6, 7, 9, 0, 'h21);
    imem[9]  = ri(0, 7, 10, 0, 'h23);
    imem[10] = ri(6, 0, 11, 0, 'h27);
    imem[11] = ii(14, 4, 12, 16'h00F0);
    imem[12] = ii(12, 4, 13, 16'h8001);
    imem[13] = ii(11, 0, 15, 16'hFFFF);
    imem[14] = ii(9, 0, 16, 16'd36);
    imem[15] = ri(16, 7, 17, 0, 4);
    imem[16] = ri(16, 3, 18, 0, 7);
    imem[17] = ii(43, 0, 9, 16'd4);
    imem[18] = ii(43, 0, 10, 16'd8);
    imem[19] = ii(43, 0, 11, 16'd12);
    imem[20] = ii(43, 0, 12, 16'd16);
    imem[21] = ii(43, 0, 13, 16'd20);
    imem[22] = ii(43, 0, 15, 16'd24);
    imem[23] = ii(43, 0, 17, 16'd28);
    imem[24] = ii(43, 0, 18, 16'd32);
    imem[25] = ii(43, 0, 8, 16'd36);
    imem[26] = ii(9, 0, 0, 16'd9);
    imem[27] = ii(43, 0, 0, 16'd40);
    imem[28] = ri(0, 0, 0, 0, 8);
    halt_word = ii(9, 2, 2, 16'd1);
    do_reset();
    exp_st("t2_sra",   32'd0,  32'hF800_0000);
    exp_st("t2_addu",  32'd4,  32'h0800_0001);
    exp_st("t2_subu",  32'd8,  32'hFFFF_FFFF);
    exp_st("t2_nor",   32'd12, 32'hF7FF_FFFF);
    exp_st("t2_xori",  32'd16, 32'hFFFF_FF0F);
    exp_st("t2_andi",  32'd20, 32'h0000_8001);
    exp_st("t2_sltiu", 32'd24, 32'd1);
    exp_st("t2_sllv",  32'd28, 32'd16);
    exp_st("t2_srav",  32'd32, 32'hF800_0000);
    exp_st("t2_sltu0", 32'd36, 32'd0);
    exp_st("t2_r0",    32'd40, 32'd0);
    exp_halt("t2_halt", 32'd1, 30);
    run_to_halt("t2", 60);
    #1 probe("t2_held", 1'b0, 32'd0, 32'd1);

    // Store then load back, including a negative offset.
    clear_imem();
    imem[0] = ii(15, 0, 5, 16'h1234);
    imem[1] = ii(13, 5, 5, 16'h5678);
    imem[2] = ii(43, 0, 5, 16'd4);
    imem[3] = ii(35, 0, 2, 16'd4);
    imem[4] = ii(9, 0, 6, 16'd16);
    imem[5] = ii(35, 6, 7, 16'hFFF4);
    imem[6] = ii(43, 6, 7, 16'd8);
    imem[7] = ri(0, 0, 0, 0, 8);
    halt_word = 32'd0;
    do_reset();
    exp_st("t3_sw", 32'd4, 32'h1234_5678);
    exp_ld("t3_lw", 32'd4);
    exp_ld("t3_lwneg", 32'd4);
    exp_st("t3_sw2", 32'd24, 32'h1234_5678);
    exp_halt("t3_halt", 32'h1234_5678, 9);
    run_to_halt("t3", 30);

    // Branches: taken/untaken, delay slots always executed.
    clear_imem();
    imem[0]  = ii(4, 0, 0, 16'd2);
    imem[1]  = ii(9, 2, 2, 16'd1);
    imem[2]  = ii(9, 2, 2, 16'd10);
    imem[3]  = ii(5, 0, 0, 16'd5);
    imem[4]  = ii(9, 2, 2, 16'd1);
    imem[5]  = ii(9, 0, 6, 16'hFFFD);
    imem[6]  = ii(1, 6, 0, 16'd2);
    imem[8]  = ii(9, 2, 2, 16'd100);
    imem[9]  = ii(1, 6, 1, 16'd2);
    imem[11] = ii(6, 0, 0, 16'd2);
    imem[12] = ii(9, 2, 2, 16'd1);
    imem[13] = ii(9, 2, 2, 16'd100);
    imem[14] = ii(7, 6, 0, 16'd1);
    imem[16] = ri(0, 0, 0, 0, 8);
    do_reset();
    exp_halt("t4_halt", 32'd3, 15);
    run_to_halt("t4", 40);

    // JAL / JR $31 and JALR / JR rd.
    clear_imem();
    imem[0]  = jj(3, BOOT + 32'd64);
    imem[1]  = ii(9, 0, 3, 16'd1);
    imem[2]  = ii(43, 0, 31, 16'd0);
    imem[3]  = ii(43, 0, 2, 16'd12);
    imem[4]  = ii(43, 0, 3, 16'd4);
    imem[5]  = ii(15, 0, 4, 16'hBFC0);
    imem[6]  = ii(13, 4, 4, 16'h0050);
    imem[7]  = ri(4, 0, 20, 0, 9);
    imem[9]  = ii(43, 0, 20, 16'd8);
    imem[10] = ri(0, 0, 0, 0, 8);
    imem[16] = ii(9, 0, 2, 16'd7);
    imem[17] = ri(31, 0, 0, 0, 8);
    imem[20] = ii(9, 2, 2, 16'd1);
    imem[21] = ri(20, 0, 0, 0, 8);
    do_reset();
    exp_st("t5_ra",    32'd0,  BOOT + 32'd8);
    exp_st("t5_v0",    32'd12, 32'd7);
    exp_st("t5_delay", 32'd4,  32'd1);
    exp_st("t5_jalr",  32'd8,  BOOT + 32'd36);
    exp_halt("t5_halt", 32'd8, 18);
    run_to_halt("t5", 50);

    // clk_enable freeze over a pending store, then async reset mid-run.
    clear_imem();
    imem[0] = ii(9, 0, 2, 16'd3);
    imem[1] = ii(43, 0, 2, 16'd0);
    imem[2] = ii(9, 2, 2, 16'd4);
    imem[3] = ii(4, 0, 0, 16'hFFFF);
    do_reset();
    exp_st("t6_sw", 32'd0, 32'd3);
    @(posedge clk);
    #2 clk_enable = 1'b0;
    #1 probe("t6_frz0", 1'b1, BOOT + 32'd4, 32'd3);
    repeat (5) @(posedge clk);
    #3 probe("t6_frz5", 1'b1, BOOT + 32'd4, 32'd3);
    clk_enable = 1'b1;
    repeat (10) @(posedge clk);
    #3 probe("t6_loop", 1'b1, BOOT + 32'd12, 32'd7);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 probe("t6_async_rst", 1'b1, BOOT, 32'd0);
    @(posedge clk);
    #3 probe("t6_rst_hold", 1'b1, BOOT, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #3 probe("t6_first", 1'b1, BOOT + 32'd4, 32'd3);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < st_q.size(); i++) unexpected({"missing_", st_q[i].nm}, st_q[i].a);
    for (int i = 0; i < ld_q.size(); i++) unexpected({"missing_", ld_q[i].nm}, ld_q[i].a);
    for (int i = 0; i < halt_q.size(); i++) unexpected({"missing_", halt_q[i].nm}, halt_q[i].d);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
